// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed N-digit seven-segment scan driver
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 50000,
  parameter int BLANK_CYC        = 16,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [7:0]              display,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           count, count_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic                    boundary;
  logic                    commit;

  logic [4*NUM_DIGITS-1:0] shadow_val, active_val;
  logic [NUM_DIGITS-1:0]   shadow_dp, active_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank, active_blank;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    lit;
  logic [7:0]              display_nx;
  logic [NUM_DIGITS-1:0]   anode_nx;

  // Active-low segment pattern g..a for one hex nibble
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h18;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Scan sequencing: blank phase then drive phase per slot; enable low parks in IDLE
  always_comb begin
    state_nx = state;
    count_nx = count;
    idx_nx   = idx;
    boundary = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      count_nx = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = BLANK;
          count_nx = '0;
          idx_nx   = '0;
        end
        BLANK: begin
          count_nx = count + CW'(1);
          if (count_nx == BLANK_END) state_nx = DRIVE;
        end
        DRIVE: begin
          if (count == CNT_LAST) begin
            count_nx = '0;
            state_nx = BLANK;
            if (idx == IDX_LAST) begin
              idx_nx   = '0;
              boundary = 1'b1;
            end else begin
              idx_nx = idx + IW'(1);
            end
          end else begin
            count_nx = count + CW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          count_nx = '0;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // A parked display may take a new frame immediately; a running one only between frames
  assign commit = pending && (boundary || (state == IDLE));

  // Select the current digit's data and build the next registered outputs
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = active_val[4*k +: 4];
        cur_dp    = active_dp[k];
        cur_blank = active_blank[k];
        onehot[k] = 1'b1;
      end
    end
    lit = enable && (state == DRIVE);
    if (lit) begin
      display_nx = cur_blank ? 8'hFF : {~cur_dp, seg7(cur_nib)};
      anode_nx   = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end else begin
      display_nx = 8'hFF;
      anode_nx   = ANODE_OFF;
    end
  end

  // Scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      idx   <= idx_nx;
    end
  end

  // Double-buffered frame: load fills shadow, commit copies it to active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      active_val   <= '0;
      active_dp    <= '0;
      active_blank <= '0;
      pending      <= 1'b0;
    end else begin
      if (commit) begin
        active_val   <= shadow_val;
        active_dp    <= shadow_dp;
        active_blank <= shadow_blank;
      end
      if (load) begin
        shadow_val   <= value;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
        pending      <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  // Registered display outputs and frame boundary pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display    <= 8'hFF;
      anode      <= ANODE_OFF;
      frame_done <= 1'b0;
    end else begin
      display    <= display_nx;
      anode      <= anode_nx;
      frame_done <= boundary;
    end
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display. It is the parametrised successor to the team's single-digit hex-to-segment decoder. It holds a double-buffered frame of hex nibbles with per-digit decimal-point and blank flags, and scans the digits at a programmable rate. A blanking interval between digits suppresses ghosting, and new frames commit only at frame boundaries so the display never tears.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8)
- SCAN_DIV, 50000, clock cycles per digit slot (≥ BLANK_CYC+1)
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off (≥1)
- ANODE_ACTIVE_LOW, 1, 1: anode enable is driven 0; 0: driven 1
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  1 = scan; 0 = display dark, scan counters held at start
- load  input  1  single-cycle strobe capturing value/dp_in/blank_in into shadow
- value  input  4*NUM_DIGITS  hex nibble per digit; digit k = value[4k+3:4k]
- dp_in  input  NUM_DIGITS  decimal point on for digit k when 1
- blank_in  input  NUM_DIGITS  digit k fully dark when 1
- display  output  8  segments, active-low, bit7 = dp, bits6:0 = g..a
- anode  output  NUM_DIGITS  one-hot digit select (polarity per ANODE_ACTIVE_LOW)
- frame_done  output  1  one-cycle pulse at each frame boundary
- pending  output  1  shadow holds a frame not yet committed

## Operation
- Reset (async, while rst_n=0): display=8'hFF, anode all inactive, frame_done=0, pending=0, shadow and active registers =0, digit index=0, slot count=0, state IDLE.
- Decode, bit6:0 with bit7=1: 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→98, A→88, b→83, C→C6, d→A1, E→86, F→8E. If dp=1, bit7 is cleared. If blank=1, output is FF and dp is ignored.
- States:
  - IDLE: enable=0. Outputs dark, count=0, idx=0. enable=1 → BLANK.
  - BLANK: count < BLANK_CYC. Anodes inactive, display=FF. When count reaches BLANK_CYC → DRIVE.
  - DRIVE: anode[idx] active; display = decode of active[idx]. At count=SCAN_DIV-1: count→0, idx→idx+1 (wraps NUM_DIGITS-1→0), → BLANK.
  - enable=0 in any state → IDLE on the next edge.
- Frame boundary: the DRIVE cycle with idx=NUM_DIGITS-1 and count=SCAN_DIV-1. On that edge:
  - If pending=1, shadow is copied to active and pending is cleared.
  - frame_done pulses during the following cycle.
- In IDLE, a pending frame commits on the next edge. frame_done does not pulse in IDLE.
- load=1: shadow ← {value, dp_in, blank_in} and pending ← 1.
  - Back-to-back loads: the last one wins.
  - load on the boundary edge: the old shadow commits, the new data enters shadow, and pending stays 1.
- Counters: count is ceil(log2(SCAN_DIV)) bits; idx is ceil(log2(NUM_DIGITS)) bits (min 1). No other arithmetic.

## Timing
- display, anode and frame_done are registered and change only on clk rising edges, except during async reset.
- From IDLE, with enable sampled 1 at edge E0:
  - BLANK for BLANK_CYC cycles.
  - Digit 0 is lit starting at edge E0+BLANK_CYC+1.
- Slot period is SCAN_DIV cycles. Frame period is NUM_DIGITS*SCAN_DIV cycles.
- A committed frame is visible starting with digit 0 of the next frame. Latency from load is at most one frame plus the current remainder.
- Outputs go dark on the first edge after enable falls. Any later enable restarts at digit 0 with a BLANK phase.
- rst_n asserted mid-frame: all outputs immediately take their reset values, and pending data is lost. After release, the block starts in IDLE.

## Test plan
Configuration for all tests: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, ANODE_ACTIVE_LOW=1.
- Reset, then enable=1, load value=16'h3210, dp=0, blank=0 → after the first frame_done, the four slots show anode 1110/1101/1011/0111 with display C0/F9/A4/B0. Each slot has 2 dark cycles (anode=1111, display=FF) followed by 6 lit cycles.
- Sweep all 16 nibbles on digit 0 with dp toggled → display matches the table; dp=1 clears bit7 (e.g. 8 with dp → 00). blank=1 on digit 2 → anode 1011 slot shows FF.
- Load 16'hAAAA mid-frame, then 16'h5555 two cycles later → the current frame is unchanged, the next frame shows 92 on all digits, and pending falls on the boundary edge.
- Load asserted on the boundary edge → the previous shadow commits, pending stays 1, and the new data shows one frame later.
- Drop enable mid-DRIVE on digit 2 → next cycle anode=1111, display=FF. Re-enable → BLANK for 2 cycles, then digit 0.
- Pulse rst_n low mid-frame with pending=1 → outputs go dark immediately, pending=0. After re-enable, digits show C0 (active cleared to 0).
